// File: rtl/servant_ram_loader.sv
// Boot loader: assembles a byte stream into 32-bit words and writes them into RAM over Wishbone.
// Optional trailing checksum byte enabled by defining SERVANT_LOADER_CSUM_EN.
module servant_ram_loader #(
    parameter int depth = 256,
    parameter int aw    = $clog2(depth)
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_dat,
    input  logic        i_vld,
    output logic        o_rdy,
    output logic [29:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic        i_wb_ack,
    output logic        o_cpu_rst,
    output logic        o_done,
    output logic        o_err
);

    // state | meaning
    // LEN0  | waiting for word count low byte
    // LEN1  | waiting for word count high byte, range check
    // ASM   | collecting payload bytes into the word buffer
    // WRITE | Wishbone write in flight, waiting for ack
    // DONE  | image loaded, CPU released
    // ERR   | load aborted, CPU held in reset
    // CSUM  | waiting for trailing XOR checksum byte (optional)
    typedef enum logic [2:0] {
        LEN0  = 3'd0,
        LEN1  = 3'd1,
        ASM   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
`ifdef SERVANT_LOADER_CSUM_EN
        ,
        CSUM  = 3'd6
`endif
    } state_t;

    localparam int          WAW   = aw - 2;
    localparam logic [15:0] WORDS = 16'(depth / 4);

    state_t          state_q, state_d;
    logic [15:0]     n_q, n_d;
    logic [1:0]      idx_q, idx_d;
    logic [31:0]     dat_q, dat_d;
    logic [WAW-1:0]  addr_q, addr_d;
`ifdef SERVANT_LOADER_CSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    logic        rdy;
    logic        xfer;
    logic        last_word;
    logic [15:0] n_new;

    always_comb begin
        rdy = 1'b0;
        unique case (state_q)
            LEN0, LEN1, ASM: rdy = 1'b1;
`ifdef SERVANT_LOADER_CSUM_EN
            CSUM:            rdy = 1'b1;
`endif
            default:         rdy = 1'b0;
        endcase
    end

    assign xfer      = i_vld & rdy;
    assign n_new     = {i_dat, n_q[7:0]};
    assign last_word = (16'(addr_q) == (n_q - 16'd1));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        addr_d  = addr_q;
`ifdef SERVANT_LOADER_CSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            LEN0: begin
`ifdef SERVANT_LOADER_CSUM_EN
                csum_d = 8'h00;
`endif
                if (xfer) begin
                    n_d[7:0] = i_dat;
                    state_d  = LEN1;
                end
            end
            LEN1: begin
                if (xfer) begin
                    n_d    = n_new;
                    idx_d  = 2'd0;
                    addr_d = '0;
                    if (n_new == 16'd0)
                        state_d = DONE;
                    else if (n_new > WORDS)
                        state_d = ERR;
                    else
                        state_d = ASM;
                end
            end
            ASM: begin
                if (xfer) begin
                    // shifting in from the top leaves the first byte in [7:0]
                    dat_d = {i_dat, dat_q[31:8]};
                    idx_d = idx_q + 2'd1;
`ifdef SERVANT_LOADER_CSUM_EN
                    csum_d = csum_q ^ i_dat;
`endif
                    if (idx_q == 2'd3)
                        state_d = WRITE;
                end
            end
            WRITE: begin
                if (i_wb_ack) begin
                    if (last_word) begin
`ifdef SERVANT_LOADER_CSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ASM;
                    end
                end
            end
`ifdef SERVANT_LOADER_CSUM_EN
            CSUM: begin
                if (xfer)
                    state_d = (i_dat == csum_q) ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                if (i_start)
                    state_d = LEN0;
            end
            default: state_d = LEN0;
        endcase
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q <= LEN0;
            n_q     <= 16'd0;
            idx_q   <= 2'd0;
            dat_q   <= 32'd0;
            addr_q  <= '0;
`ifdef SERVANT_LOADER_CSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            addr_q  <= addr_d;
`ifdef SERVANT_LOADER_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // cyc is decoded from state so an async reset drops it without a handshake
    assign o_rdy     = rdy;
    assign o_wb_cyc  = (state_q == WRITE);
    assign o_wb_we   = o_wb_cyc;
    assign o_wb_sel  = 4'hF;
    assign o_wb_adr  = {{(30 - WAW){1'b0}}, addr_q};
    assign o_wb_dat  = dat_q;
    assign o_done    = (state_q == DONE);
    assign o_err     = (state_q == ERR);
    assign o_cpu_rst = (state_q != DONE);

endmodule

// File: tb/tb_servant_ram_loader.sv
// Directed bench for servant_ram_loader with a Wishbone RAM model that delays ack by 0-3 cycles.
module tb_servant_ram_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_dat = 8'h00;
    logic        i_vld = 1'b0;
    logic        o_rdy;
    logic [29:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic        i_wb_ack;
    logic        o_cpu_rst;
    logic        o_done;
    logic        o_err;

    servant_ram_loader #(.depth(256)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_start    (i_start),
        .i_dat      (i_dat),
        .i_vld      (i_vld),
        .o_rdy      (o_rdy),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .o_wb_sel   (o_wb_sel),
        .o_wb_we    (o_wb_we),
        .o_wb_cyc   (o_wb_cyc),
        .i_wb_ack   (i_wb_ack),
        .o_cpu_rst  (o_cpu_rst),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // RAM model and bus monitor
    logic [31:0] mem [0:63];
    logic [1:0]  wcnt = 2'd0;
    bit          dly_en = 1'b0;
    int          edge_n = 0;
    int          last_ack_edge = -1000;
    int          rises = 0;
    int          writes = 0;
    int          viol = 0;
    logic        prev_cyc = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_wb_ack <= 1'b0;
            wcnt     <= 2'd0;
        end else if (!o_wb_cyc) begin
            i_wb_ack <= 1'b0;
            wcnt     <= dly_en ? 2'($urandom_range(3, 0)) : 2'd0;
        end else if (i_wb_ack) begin
            i_wb_ack <= 1'b0;
        end else if (wcnt == 2'd0) begin
            i_wb_ack <= 1'b1;
        end else begin
            wcnt <= wcnt - 2'd1;
        end
    end

    always @(posedge clk) begin
        edge_n   <= edge_n + 1;
        prev_cyc <= o_wb_cyc;
        if (o_wb_cyc && !prev_cyc) rises <= rises + 1;
        if ((o_wb_we !== o_wb_cyc) || (o_wb_sel !== 4'hF)) viol <= viol + 1;
        if (o_wb_cyc && i_wb_ack) begin
            mem[o_wb_adr[5:0]] <= o_wb_dat;
            writes             <= writes + 1;
            last_ack_edge      <= edge_n;
        end
    end

    logic [7:0] stim [$];

    task automatic send_byte(input logic [7:0] b);
        logic r;
        bit   got;
        got   = 1'b0;
        i_dat = b;
        i_vld = 1'b1;
        for (int t = 0; t < 400 && !got; t++) begin
            r = o_rdy;
            @(negedge clk);
            if (r) got = 1'b1;
        end
        i_vld = 1'b0;
        if (!got) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic play(input int gap_max);
        foreach (stim[i]) begin
            send_byte(stim[i]);
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        end
        stim.delete();
    endtask

    task automatic add_csum();
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < stim.size(); i++) x = x ^ stim[i];
        stim.push_back(x);
    endtask

    task automatic wait_end(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int t = 0; t < 3000 && !seen; t++) begin
            if (o_done || o_err) begin
                seen = 1'b1;
                lat  = edge_n - last_ack_edge;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) chk("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("start_rearm_rdy", 32'(o_rdy), 32'd1);
        chk("start_rearm_cpu_rst", 32'(o_cpu_rst), 32'd1);
    endtask

    int          lat;
    int          r0, nbad;
    logic [31:0] exp_w [0:63];

    initial begin
        #12;
        chk("rst_rdy", 32'(o_rdy), 32'd1);
        chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
        chk("rst_we", 32'(o_wb_we), 32'd0);
        chk("rst_adr", 32'(o_wb_adr), 32'd0);
        chk("rst_dat", o_wb_dat, 32'd0);
        chk("rst_cpu_rst", 32'(o_cpu_rst), 32'd1);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // two-word image
        r0 = rises;
        stim = '{8'h02, 8'h00, 8'h13, 8'h04, 8'h10, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
`ifdef SERVANT_LOADER_CSUM_EN
        add_csum();
`endif
        play(0);
        wait_end(lat);
        chk("t1_word0", mem[0], 32'h00100413);
        chk("t1_word1", mem[1], 32'h00100073);
        chk("t1_done", 32'(o_done), 32'd1);
        chk("t1_cpu_rst", 32'(o_cpu_rst), 32'd0);
        chk("t1_cycles", 32'(rises - r0), 32'd2);
`ifndef SERVANT_LOADER_CSUM_EN
        chk("t1_done_latency", 32'(lat), 32'd1);
`endif
        pulse_start();

        // empty image
        r0 = rises;
        stim = '{8'h00, 8'h00};
        play(0);
        wait_end(lat);
        chk("t2_done", 32'(o_done), 32'd1);
        chk("t2_cpu_rst", 32'(o_cpu_rst), 32'd0);
        chk("t2_no_cycle", 32'(rises - r0), 32'd0);
        pulse_start();

        // oversize image, then recovery
        r0 = rises;
        stim = '{8'h41, 8'h00};
        play(0);
        wait_end(lat);
        chk("t3_err", 32'(o_err), 32'd1);
        chk("t3_cpu_rst", 32'(o_cpu_rst), 32'd1);
        chk("t3_rdy", 32'(o_rdy), 32'd0);
        chk("t3_no_cycle", 32'(rises - r0), 32'd0);
        pulse_start();
        chk("t3_err_cleared", 32'(o_err), 32'd0);
        stim = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef SERVANT_LOADER_CSUM_EN
        add_csum();
`endif
        play(0);
        wait_end(lat);
        chk("t3_word0", mem[0], 32'hDDCCBBAA);
        chk("t3_done", 32'(o_done), 32'd1);
        pulse_start();

        // full-capacity image with stream gaps and ack delays
        dly_en = 1'b1;
        r0 = rises;
        stim = '{8'h40, 8'h00};
        for (int i = 0; i < 64; i++) begin
            exp_w[i] = $urandom;
            stim.push_back(exp_w[i][7:0]);
            stim.push_back(exp_w[i][15:8]);
            stim.push_back(exp_w[i][23:16]);
            stim.push_back(exp_w[i][31:24]);
        end
`ifdef SERVANT_LOADER_CSUM_EN
        add_csum();
`endif
        play(2);
        wait_end(lat);
        nbad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== exp_w[i]) nbad++;
        chk("t4_bad_words", 32'(nbad), 32'd0);
        chk("t4_done", 32'(o_done), 32'd1);
        chk("t4_last_adr", 32'(o_wb_adr), 32'd63);
        chk("t4_cycles", 32'(rises - r0), 32'd64);
        chk("t4_bus_viol", 32'(viol), 32'd0);
        dly_en = 1'b0;
        pulse_start();

        // async reset while a write is in flight
        stim = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        play(0);
        chk("t5_cyc_before", 32'(o_wb_cyc), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_cyc", 32'(o_wb_cyc), 32'd0);
        chk("t5_we", 32'(o_wb_we), 32'd0);
        chk("t5_rdy", 32'(o_rdy), 32'd1);
        chk("t5_adr", 32'(o_wb_adr), 32'd0);
        chk("t5_dat", o_wb_dat, 32'd0);
        chk("t5_cpu_rst", 32'(o_cpu_rst), 32'd1);
        chk("t5_done", 32'(o_done), 32'd0);
        chk("t5_err", 32'(o_err), 32'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        stim = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef SERVANT_LOADER_CSUM_EN
        add_csum();
`endif
        play(0);
        wait_end(lat);
        chk("t5_word0", mem[0], 32'h12345678);
        chk("t5_done_after", 32'(o_done), 32'd1);

`ifdef SERVANT_LOADER_CSUM_EN
        pulse_start();
        stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h44, 8'h88, 8'hFF};
        play(0);
        wait_end(lat);
        chk("csum_ok_done", 32'(o_done), 32'd1);
        chk("csum_ok_word0", mem[0], 32'h88442211);
        pulse_start();
        stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h44, 8'h88, 8'h00};
        play(0);
        wait_end(lat);
        chk("csum_bad_err", 32'(o_err), 32'd1);
        chk("csum_bad_cpu_rst", 32'(o_cpu_rst), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/servant_ram_loader.md
Name: servant_ram_loader

Overview:
Boot loader stage directly upstream of the servant on-chip RAM. It accepts a byte stream through a valid/ready interface, assembles little-endian 32-bit words, and writes them sequentially into the RAM over the Wishbone classic port from word address 0. It holds the CPU in reset until the image has been fully written.

Parameters:
depth, 256, RAM size in bytes; word capacity is depth/4.
aw, $clog2(depth), byte address width.

Ports:
i_wb_clk  in  1  clock
i_wb_rst_n  in  1  asynchronous active-low reset
i_start  in  1  single-cycle pulse; re-arms the loader from DONE or ERR
i_dat  in  8  stream byte
i_vld  in  1  stream byte valid
o_rdy  out  1  loader can accept a byte
o_wb_adr  out  30  word address [31:2]
o_wb_dat  out  32  write data
o_wb_sel  out  4  byte enables; always 4'hF
o_wb_we  out  1  write enable; equals o_wb_cyc
o_wb_cyc  out  1  cycle request
i_wb_ack  in  1  RAM acknowledge
o_cpu_rst  out  1  CPU reset request (active high)
o_done  out  1  image loaded
o_err  out  1  load aborted

Behaviour:
- Reset: state=LEN0, o_rdy=1, o_wb_cyc=0, o_wb_we=0, o_wb_adr=0, o_wb_dat=0, o_cpu_rst=1, o_done=0, o_err=0, word count N=0, byte index=0.
- A byte is transferred on a rising edge where i_vld & o_rdy. o_rdy is registered-state decoded: 1 in LEN0, LEN1, ASM and CSUM; 0 in all other states.
- LEN0: capture N[7:0], then go to LEN1.
- LEN1: capture N[15:8].
  - N==0 -> DONE.
  - N > depth/4 -> ERR.
  - Otherwise -> ASM, with address=0.
- ASM: shift bytes into the word buffer little-endian; the first byte goes to [7:0].
  - On the 4th byte: o_wb_dat=word, o_wb_cyc=1, and go to WRITE.
- WRITE: o_wb_cyc, o_wb_we and o_wb_sel remain stable until i_wb_ack is sampled high.
  - On that edge, o_wb_cyc drops to 0 and the address increments.
  - If the written word was word N-1 -> DONE (or CSUM when the feature is enabled). Otherwise -> ASM.
  - o_wb_cyc must be low for at least 1 cycle between writes. The RAM acks 1 cycle after cyc and toggles its ack if cyc is held; the duplicate write this causes is benign.
- Latency: from the edge that accepts the 4th byte, cyc is high 1 cycle later, ack arrives 1 cycle after that, and o_rdy returns the cycle after ack. Minimum throughput is 6 cycles per word.
- DONE: o_done=1, o_cpu_rst=0, o_rdy=0.
- ERR: o_err=1, o_cpu_rst=1, o_rdy=0.
- i_start in DONE or ERR: clear o_done and o_err, set o_cpu_rst=1, go to LEN0. i_start is ignored in every other state.
- Address width: o_wb_adr = {zeros, addr[aw-3:0]}. The address never wraps, because N ≤ depth/4 is checked before any write.
- Asynchronous reset mid-WRITE: o_wb_cyc drops immediately with no ack handshake. The RAM may complete or drop the write; the partial image is discarded.
- i_vld while o_rdy=0: the byte is not consumed; the source holds it.

Optional Feature:
SERVANT_LOADER_CSUM_EN.
- Defined: after the last word is acked, go to CSUM. The next accepted byte is compared against the running XOR of all payload bytes (the length bytes are excluded). Match -> DONE; mismatch -> ERR. The running XOR is cleared in LEN0.
- Undefined: no CSUM state; the FSM goes from the last write directly to DONE.

Test Plan:
- Reset, then stream 02 00 | 13 04 10 00 | 73 00 10 00 -> RAM word0=0x00100413, word1=0x00100073; o_done=1 and o_cpu_rst=0 exactly 1 cycle after the second ack.
- Stream 00 00 -> DONE with no Wishbone cycle; o_cpu_rst=0.
- Stream 41 00 with depth=256 (N=65 > 64) -> o_err=1, o_cpu_rst=1, o_wb_cyc never asserted. Then pulse i_start, stream 01 00 AA BB CC DD -> word0=0xDDCCBBAA, o_done=1.
- Stream N=64 with random i_vld gaps and a RAM model delaying ack by 0-3 cycles -> all 64 words correct, address stops at 63, no byte lost or duplicated, cyc low ≥1 cycle between writes.
- Assert i_wb_rst_n low mid-WRITE -> o_wb_cyc=0 in the same cycle and all outputs at reset values. A following full load of N=1 succeeds.
- With SERVANT_LOADER_CSUM_EN defined: 01 00 11 22 44 88 FF -> DONE; the same stream with a final 00 -> ERR.
